// File: rtl/cache_wb_buffer_pkg.sv
// Shared encodings, AXI constants, FSM states and request decode for the write buffer.
package cache_wb_buffer_pkg;

  // Cache write request types
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  // AXI constants
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  // FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_XFER = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Burst header captured at accept time
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  strb;
  } aw_hdr_t;

  // Map a cache write request onto an AXI burst header; unknown types act as word
  function automatic aw_hdr_t decode_req(input logic [2:0]  wr_type,
                                         input logic [31:0] wr_addr,
                                         input logic [3:0]  wr_wstrb,
                                         input int unsigned offset_width,
                                         input int unsigned words);
    aw_hdr_t h;
    h.addr = wr_addr;
    h.len  = 8'd0;
    h.size = SIZE_4B;
    h.strb = wr_wstrb;
    case (wr_type)
      TYPE_BYTE: h.size = 3'b000;
      TYPE_HALF: h.size = 3'b001;
      TYPE_LINE: begin
        h.addr = wr_addr & ~((32'd1 << offset_width) - 32'd1);
        h.len  = 8'(words - 1);
        h.strb = 4'hF;
      end
      default: h.size = SIZE_4B;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/cache_wb_buffer_if.sv
// Cache line-write port, refill hazard check and AXI AW/W/B channels.
interface cache_wb_buffer_if #(
  parameter int unsigned BYTES_PER_LINE = 16
);
  logic                        wr_req;
  logic [2:0]                  wr_type;
  logic [31:0]                 wr_addr;
  logic [3:0]                  wr_wstrb;
  logic [BYTES_PER_LINE*8-1:0] wr_data;
  logic                        wr_rdy;
  logic [31:0]                 chk_addr;
  logic                        chk_hit;
  logic [31:0]                 awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;
  logic [31:0]                 wdata;
  logic [3:0]                  wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  logic                        bvalid;
  logic                        bready;

  // The write buffer: cache-side target, AXI write master
  modport master (
    input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data, chk_addr,
    input  awready, wready, bvalid,
    output wr_rdy, chk_hit,
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready
  );

  // The surroundings: cache requester plus AXI slave
  modport slave (
    output wr_req, wr_type, wr_addr, wr_wstrb, wr_data, chk_addr,
    output awready, wready, bvalid,
    input  wr_rdy, chk_hit,
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/cache_wb_buffer.sv
// Single-entry write buffer: captures one line eviction or uncached store and drains it as an AXI INCR burst.
module cache_wb_buffer
  import cache_wb_buffer_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic             clk,
  input  logic             resetn,
  cache_wb_buffer_if.master bus
);

  localparam int unsigned WORDS_PER_LINE = BYTES_PER_LINE / 4;
  localparam int unsigned OFFSET_WIDTH   = $clog2(BYTES_PER_LINE);
  localparam int unsigned DATA_W         = BYTES_PER_LINE * 8;

  state_t            state_q, state_d;
  logic              aw_done_q, w_done_q;
  logic [7:0]        beat_q;
  logic [DATA_W-1:0] data_q;
  aw_hdr_t           hdr_c;
  logic              aw_hs_c, w_hs_c, w_last_hs_c;

  assign hdr_c       = decode_req(bus.wr_type, bus.wr_addr, bus.wr_wstrb, OFFSET_WIDTH, WORDS_PER_LINE);
  assign aw_hs_c     = bus.awvalid && bus.awready;
  assign w_hs_c      = bus.wvalid && bus.wready;
  assign w_last_hs_c = w_hs_c && bus.wlast;

  // Cache-facing status is combinational so the cache sees it the same cycle
  assign bus.wr_rdy  = (state_q == ST_IDLE);
  assign bus.chk_hit = (state_q != ST_IDLE) &&
                       (bus.chk_addr[31:OFFSET_WIDTH] == bus.awaddr[31:OFFSET_WIDTH]);
  assign bus.awburst = BURST_INCR;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: leave XFER once both AW and the last W beat are done, in either order
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.wr_req) state_d = ST_XFER;
      ST_XFER: if ((aw_done_q || aw_hs_c) && (w_done_q || w_last_hs_c)) state_d = ST_RESP;
      ST_RESP: if (bus.bvalid && bus.bready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture, AW/W channel drive and beat sequencing; remaining words shift down one per beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.awaddr  <= '0;
      bus.awlen   <= '0;
      bus.awsize  <= '0;
      bus.awvalid <= 1'b0;
      bus.wdata   <= '0;
      bus.wstrb   <= '0;
      bus.wlast   <= 1'b0;
      bus.wvalid  <= 1'b0;
      bus.bready  <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      beat_q      <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.wr_req) begin
            bus.awaddr  <= hdr_c.addr;
            bus.awlen   <= hdr_c.len;
            bus.awsize  <= hdr_c.size;
            bus.wstrb   <= hdr_c.strb;
            bus.wdata   <= bus.wr_data[31:0];
            bus.wlast   <= (hdr_c.len == 8'd0);
            bus.awvalid <= 1'b1;
            bus.wvalid  <= 1'b1;
            data_q      <= bus.wr_data >> 32;
            beat_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
          end
        end
        ST_XFER: begin
          if (aw_hs_c) begin
            bus.awvalid <= 1'b0;
            aw_done_q   <= 1'b1;
          end
          if (w_hs_c) begin
            if (bus.wlast) begin
              bus.wvalid <= 1'b0;
              bus.wlast  <= 1'b0;
              w_done_q   <= 1'b1;
            end else begin
              beat_q    <= beat_q + 8'd1;
              bus.wdata <= data_q[31:0];
              data_q    <= data_q >> 32;
              bus.wlast <= ((beat_q + 8'd1) == bus.awlen);
            end
          end
          if (state_d == ST_RESP) bus.bready <= 1'b1;
        end
        ST_RESP: begin
          if (bus.bvalid) begin
            bus.bready <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            beat_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
